// File: rtl/bht_update_sched.sv
// Branch history table of 2-bit saturating counters behind one shared port.
// Fetch lookups take priority; resolved-branch updates queue in a FIFO and retire on idle port cycles.
module bht_update_sched #(
  parameter int         IDX_W      = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] CNT_INIT   = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             lkp_valid,
  input  logic [IDX_W-1:0] lkp_idx,
  output logic             lkp_pred,
  output logic             lkp_pred_valid,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             busy
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_walk_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_tbl      [ENTRIES];
  logic [IDX_W-1:0] r_fifo_idx [FIFO_DEPTH];
  logic             r_fifo_tkn [FIFO_DEPTH];

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_count_nx;
  logic             w_run;
  logic             w_lkp;
  logic             w_clr;
  logic             w_push;
  logic             w_pop;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_tkn;
  logic [1:0]       w_head_cnt;
  logic             w_ready_nx;
  logic             w_busy_nx;

  function automatic logic [1:0] f_sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == 2'd3) ? 2'd3 : cnt + 2'd1;
    end else begin
      res = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
    end
    return res;
  endfunction

  // Port arbitration, queue bookkeeping and next-state decode.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_lkp      = w_run & lkp_valid;
    w_clr      = w_run & clear;
    // A push coinciding with clear is dropped along with the rest of the queue.
    w_push     = upd_valid & upd_ready & ~clear;
    w_pop      = w_run & ~lkp_valid & ~clear & (r_count != '0);
    w_head_idx = r_fifo_idx[r_rd_ptr];
    w_head_tkn = r_fifo_tkn[r_rd_ptr];
    w_head_cnt = r_tbl[w_head_idx];

    case (r_state)
      ST_INIT, ST_CLEAR: w_state_nx = (&r_walk_ptr) ? ST_RUN : r_state;
      ST_RUN:            w_state_nx = clear ? ST_CLEAR : ST_RUN;
      default:           w_state_nx = ST_INIT;
    endcase

    if (w_clr) begin
      w_count_nx = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_nx = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   w_count_nx = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: w_count_nx = r_count;
      endcase
    end

    w_ready_nx = (w_state_nx == ST_RUN) && (w_count_nx < CNT_W'(FIFO_DEPTH));
    w_busy_nx  = (w_state_nx != ST_RUN) || (w_count_nx != '0);
  end

  // Control state, queue pointers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_INIT;
      r_walk_ptr     <= '0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
      lkp_pred       <= 1'b0;
      lkp_pred_valid <= 1'b0;
      upd_ready      <= 1'b0;
      busy           <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      if (!w_run) begin
        r_walk_ptr <= r_walk_ptr + {{(IDX_W-1){1'b0}}, 1'b1};
      end else if (w_clr) begin
        r_walk_ptr <= '0;
      end else begin
        r_walk_ptr <= r_walk_ptr;
      end
      if (w_clr) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        if (w_pop)  r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      r_count        <= w_count_nx;
      lkp_pred_valid <= w_lkp;
      if (w_lkp) lkp_pred <= r_tbl[lkp_idx][1];
      upd_ready      <= w_ready_nx;
      busy           <= w_busy_nx;
    end
  end

  // Update queue storage; contents are meaningless outside [rd_ptr, wr_ptr).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_idx[r_wr_ptr] <= upd_idx;
      r_fifo_tkn[r_wr_ptr] <= upd_taken;
    end
  end

  // Counter table: init/clear walk outside RUN, read-modify-write of the queue head in RUN.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_tbl[r_walk_ptr] <= CNT_INIT;
    end else if (w_pop) begin
      r_tbl[w_head_idx] <= f_sat_step(w_head_cnt, w_head_tkn);
    end
  end

endmodule

// File: tb/tb_bht_update_sched.sv
// Randomised scoreboard bench for bht_update_sched against a queue/array reference model.
module tb_bht_update_sched;
  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam int N     = 16;

  typedef struct {
    int idx;
    bit tkn;
  } upd_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             lkp_valid = 1'b0;
  logic [IDX_W-1:0] lkp_idx = '0;
  logic             upd_valid = 1'b0;
  logic [IDX_W-1:0] upd_idx = '0;
  logic             upd_taken = 1'b0;
  logic             lkp_pred;
  logic             lkp_pred_valid;
  logic             upd_ready;
  logic             busy;

  int   checks = 0;
  int   failures = 0;
  int   mtbl [N];
  upd_t mq [$];
  bit   sb [$];
  int   walk = N;

  always #5 clk = ~clk;

  bht_update_sched #(.IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .CNT_INIT(2'b00)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .lkp_valid(lkp_valid), .lkp_idx(lkp_idx),
    .lkp_pred(lkp_pred), .lkp_pred_valid(lkp_pred_valid),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_wipe();
    for (int i = 0; i < N; i++) mtbl[i] = 0;
    mq.delete();
  endtask

  // Monitor: every presented prediction is matched against the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b1 && lkp_pred_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pred_valid actual=1 required=0 at %0t", $time);
      end else begin
        chk("lkp_pred", {31'd0, lkp_pred}, {31'd0, sb.pop_front()});
      end
    end
  end

  // One cycle: check status outputs, drive inputs, advance the model across the next edge.
  task automatic cycle(input bit lv, input int li, input bit uv, input int ui, input bit ut, input bit clr);
    bit   er;
    bit   eb;
    upd_t u;
    er = (walk == 0) && (mq.size() < DEPTH);
    eb = (walk != 0) || (mq.size() != 0);
    chk("upd_ready", {31'd0, upd_ready}, {31'd0, er});
    chk("busy", {31'd0, busy}, {31'd0, eb});
    lkp_valid = lv;
    lkp_idx   = li[IDX_W-1:0];
    upd_valid = uv;
    upd_idx   = ui[IDX_W-1:0];
    upd_taken = ut;
    clear     = clr;
    if (walk > 0) begin
      walk--;
    end else begin
      if (lv) sb.push_back(mtbl[li] >= 2);
      if (clr) begin
        model_wipe();
        walk = N;
      end else begin
        if (!lv && mq.size() > 0) begin
          u = mq.pop_front();
          if (u.tkn) mtbl[u.idx] = (mtbl[u.idx] == 3) ? 3 : mtbl[u.idx] + 1;
          else       mtbl[u.idx] = (mtbl[u.idx] == 0) ? 0 : mtbl[u.idx] - 1;
        end
        if (uv && er) begin
          u.idx = ui;
          u.tkn = ut;
          mq.push_back(u);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic lookup(input int li);
    cycle(1'b1, li, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic push(input int ui, input bit ut);
    cycle(1'b0, 0, 1'b1, ui, ut, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_lkp_pred"}, {31'd0, lkp_pred}, 32'd0);
    chk({tag, "_lkp_pred_valid"}, {31'd0, lkp_pred_valid}, 32'd0);
    chk({tag, "_upd_ready"}, {31'd0, upd_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    walk  = N;
    model_wipe();
  endtask

  task automatic mid_reset();
    #2 reset = 1'b0;
    #1 check_reset_outputs("async_rst");
    lkp_valid = 1'b0;
    upd_valid = 1'b0;
    clear     = 1'b0;
    model_wipe();
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    release_reset();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    release_reset();

    // T1: init walk then a lookup of an initialised entry
    idle(N);
    lookup(3);
    idle(2);

    // T2: three taken updates drain back to back
    for (int i = 0; i < 3; i++) push(5, 1'b1);
    idle(4);
    lookup(5);
    lookup(6);
    idle(2);

    // T3: saturation at both ends on entry 2
    for (int i = 0; i < 5; i++) push(2, 1'b1);
    push(2, 1'b0);
    idle(7);
    lookup(2);
    for (int i = 0; i < 2; i++) push(2, 1'b0);
    idle(3);
    lookup(2);
    push(2, 1'b0);
    push(2, 1'b1);
    idle(3);
    lookup(2);
    push(2, 1'b1);
    idle(2);
    lookup(2);
    idle(2);

    // T4: lookups hold the port while the queue fills
    for (int i = 0; i < 5; i++) cycle(1'b1, 7, 1'b1, 8 + i, 1'b1, 1'b0);
    idle(4);
    push(12, 1'b1);
    idle(3);
    for (int i = 8; i < 13; i++) lookup(i);
    idle(2);

    // T5: clear discards queued updates and re-walks the table
    for (int i = 0; i < 3; i++) cycle(1'b1, 0, 1'b1, 1 + i, 1'b1, 1'b0);
    cycle(1'b1, 4, 1'b0, 0, 1'b0, 1'b1);
    idle(N);
    for (int i = 0; i < N; i++) lookup(i);
    idle(2);

    // T6: asynchronous reset while the queue is draining
    for (int i = 0; i < 4; i++) cycle(1'b1, 1, 1'b1, 9, 1'b1, 1'b0);
    idle(2);
    mid_reset();
    idle(N + 2);

    // Randomised traffic with occasional clears
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 99) < 35), $urandom_range(0, N - 1),
            ($urandom_range(0, 99) < 60), $urandom_range(0, N - 1),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 149) == 0));
    end
    idle(DEPTH + N + 4);
    for (int i = 0; i < N; i++) lookup(i);
    idle(3);
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
